// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA character writer:
//   POS_LIMIT_DEFAULT : number of valid character cells (40x30 text mode)
//   CLEAR_CMD         : character word that means "clear the screen" when the
//                       optional clear feature is built in
//   fb_entry_t        : one queued framebuffer write {addr, data}
//   state_e           : writer state (IDLE draining the queue, CLEAR filling)
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned POS_LIMIT_DEFAULT = 1200;
  localparam logic [15:0] CLEAR_CMD         = 16'hFFFF;

  // addr holds the full 16-bit cell index; the top narrows it to ADDR_W.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } fb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/vga_char_writer_char_fifo.sv
// ---------------------------------------------------------------------------
// char_fifo
// Parameterised synchronous FIFO with natural-wrap pointers.
// Ports:
//   clock, reset      : clock, asynchronous active-high reset
//   i_push, i_data    : write request and word (ignored while full)
//   i_pop             : remove the head entry (ignored while empty)
//   o_head            : current head entry (valid while o_count != 0)
//   o_count           : number of stored entries, 0..DEPTH
//   o_full            : o_count == DEPTH
// ---------------------------------------------------------------------------
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && (r_count != '0);

  // NOTE: the storage array has no reset; only pointers and count need a
  // known value, and leaving the RAM unreset lets it map onto memory cells.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/vga_char_writer.sv
// ---------------------------------------------------------------------------
// vga_char_writer
// Queues CPU character writes (rising edge of videoflag) and drains them into
// the text framebuffer write port in cycles where the scanout arbiter grants
// access. Out-of-range positions and requests arriving while full are
// dropped and counted (saturating at 255).
// Optional feature, macro VGA_CLEAR_SCREEN_EN: a request whose character word
// is 16'hFFFF becomes a clear command that fills every cell with CLEAR_CHAR
// once it reaches the queue head.
// Ports:
//   clock, reset            : 25 MHz video clock, async active-high reset
//   videoflag               : CPU write strobe (level; request = rising edge)
//   vga_pos, vga_char       : cell index and char/colour word of the request
//   fb_grant                : arbiter grant for this cycle
//   fb_we, fb_addr, fb_data : framebuffer write port (combinational)
//   busy                    : queue non-empty or clear in progress
//   full                    : queue holds DEPTH entries
//   drop_count              : saturating count of rejected requests
// ---------------------------------------------------------------------------
module vga_char_writer
  import vga_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter int          POS_LIMIT  = POS_LIMIT_DEFAULT,
  parameter int          ADDR_W     = 11,
  parameter logic [15:0] CLEAR_CHAR = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              videoflag,
  input  logic [15:0]       vga_pos,
  input  logic [15:0]       vga_char,
  input  logic              fb_grant,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              busy,
  output logic              full,
  output logic [7:0]        drop_count
);

  logic                   r_vflag;
  logic [7:0]             r_drop_count;
  logic                   w_req;
  logic                   w_pos_ok;
  logic                   w_is_clr_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic [$clog2(DEPTH):0] w_count;
  fb_entry_t              w_push_entry;
  fb_entry_t              w_head;

  assign w_req    = videoflag && !r_vflag;
  assign w_pos_ok = (32'(vga_pos) < 32'(POS_LIMIT));

`ifdef VGA_CLEAR_SCREEN_EN
  assign w_is_clr_req = (vga_char == CLEAR_CMD);
`else
  assign w_is_clr_req = 1'b0;
`endif

  // Full is the registered count, so a push racing a pop while full drops.
  assign w_push       = w_req && !w_full && (w_pos_ok || w_is_clr_req);
  assign w_push_entry = '{addr: vga_pos, data: vga_char};

  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fb_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vflag      <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_vflag <= videoflag;
      if (w_req && !w_push && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

`ifdef VGA_CLEAR_SCREEN_EN
  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= w_clr_idx_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_clr_idx_next = r_clr_idx;
    w_pop          = 1'b0;
    fb_we          = 1'b0;
    fb_addr        = '0;
    fb_data        = '0;
    case (r_state)
      IDLE: begin
        if ((w_count != '0) && fb_grant) begin
          w_pop = 1'b1;
          // A clear command is consumed without a framebuffer write.
          if (w_head.data == CLEAR_CMD) begin
            w_state_next   = CLEAR;
            w_clr_idx_next = '0;
          end else begin
            fb_we   = 1'b1;
            fb_addr = w_head.addr[ADDR_W-1:0];
            fb_data = w_head.data;
          end
        end
      end
      CLEAR: begin
        if (fb_grant) begin
          fb_we   = 1'b1;
          fb_addr = r_clr_idx;
          fb_data = CLEAR_CHAR;
          if (r_clr_idx == ADDR_W'(POS_LIMIT - 1)) begin
            w_state_next = IDLE;
          end else begin
            w_clr_idx_next = r_clr_idx + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy = (w_count != '0) || (r_state == CLEAR);
`else
  always_comb begin
    w_pop   = 1'b0;
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    if ((w_count != '0) && fb_grant) begin
      w_pop   = 1'b1;
      fb_we   = 1'b1;
      fb_addr = w_head.addr[ADDR_W-1:0];
      fb_data = w_head.data;
    end
  end

  assign busy = (w_count != '0);
`endif

  assign full       = w_full;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_vga_char_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_char_writer
// Self-checking bench for vga_char_writer: a queue-based reference model is
// compared against the DUT on every falling clock edge, directed scenarios
// pin concrete values, and a randomized phase mixes grants, strobes, bad
// positions and occasional resets. Honours VGA_CLEAR_SCREEN_EN.
// ---------------------------------------------------------------------------
module tb_vga_char_writer;

  localparam int          DEPTH      = 8;
  localparam int          POS_LIMIT  = 1200;
  localparam int          ADDR_W     = 11;
  localparam logic [15:0] CLEAR_CHAR = 16'h0000;

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic              videoflag = 1'b0;
  logic [15:0]       vga_pos   = '0;
  logic [15:0]       vga_char  = '0;
  logic              fb_grant  = 1'b0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_data;
  logic              busy;
  logic              full;
  logic [7:0]        drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  vga_char_writer #(
    .DEPTH      (DEPTH),
    .POS_LIMIT  (POS_LIMIT),
    .ADDR_W     (ADDR_W),
    .CLEAR_CHAR (CLEAR_CHAR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .videoflag  (videoflag),
    .vga_pos    (vga_pos),
    .vga_char   (vga_char),
    .fb_grant   (fb_grant),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy),
    .full       (full),
    .drop_count (drop_count)
  );

  always #20 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_clear_cmd(input logic [15:0] ch);
`ifdef VGA_CLEAR_SCREEN_EN
    return ch == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- reference model + per-cycle compare -------------------
  typedef struct {
    logic [15:0] pos;
    logic [15:0] ch;
  } req_t;

  req_t        mq[$];
  bit          m_prev_vf = 1'b0;
  int          m_drops   = 0;
  bit          m_clr     = 1'b0;
  int          m_idx     = 0;
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];

  always @(negedge clock) begin : model
    bit   pop;
    bit   clr_start;
    bit   req;
    bit   was_full;
    logic exp_we;
    int   exp_addr;
    int   exp_data;
    pop = 1'b0; clr_start = 1'b0; exp_we = 1'b0; exp_addr = 0; exp_data = 0;
    if (reset) begin
      mq.delete();
      m_prev_vf = 1'b0; m_drops = 0; m_clr = 1'b0; m_idx = 0;
      check("rst_fb_we", 32'(fb_we), 0);
      check("rst_fb_addr", 32'(fb_addr), 0);
      check("rst_fb_data", 32'(fb_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_full", 32'(full), 0);
      check("rst_drop", 32'(drop_count), 0);
    end else begin
      if (m_clr) begin
        if (fb_grant) begin
          exp_we = 1'b1; exp_addr = m_idx; exp_data = int'(CLEAR_CHAR);
        end
      end else if (mq.size() > 0 && fb_grant) begin
        pop = 1'b1;
        if (is_clear_cmd(mq[0].ch)) clr_start = 1'b1;
        else begin
          exp_we = 1'b1; exp_addr = int'(mq[0].pos); exp_data = int'(mq[0].ch);
        end
      end
      check("fb_we", 32'(fb_we), 32'(exp_we));
      if (exp_we) begin
        check("fb_addr", 32'(fb_addr), exp_addr);
        check("fb_data", 32'(fb_data), exp_data);
        log_addr.push_back(16'(fb_addr));
        log_data.push_back(fb_data);
      end
      check("busy", 32'(busy), 32'(mq.size() != 0 || m_clr));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("drop_count", 32'(drop_count), m_drops);
      // advance to the next rising edge
      req      = videoflag && !m_prev_vf;
      was_full = (mq.size() == DEPTH);
      if (m_clr && fb_grant) begin
        if (m_idx == POS_LIMIT - 1) m_clr = 1'b0;
        else m_idx++;
      end
      if (pop) void'(mq.pop_front());
      if (clr_start) begin m_clr = 1'b1; m_idx = 0; end
      if (req) begin
        if (!was_full && (int'(vga_pos) < POS_LIMIT || is_clear_cmd(vga_char)))
          mq.push_back('{pos: vga_pos, ch: vga_char});
        else if (m_drops < 255)
          m_drops++;
      end
      m_prev_vf = videoflag;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic request(input logic [15:0] pos, input logic [15:0] ch);
    @(posedge clock); #1;
    videoflag = 1'b1; vga_pos = pos; vga_char = ch;
    @(posedge clock); #1;
    videoflag = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; videoflag = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic midcycle_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_we"}, 32'(fb_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_drop"}, 32'(drop_count), 0);
    check({tag, "_addr"}, 32'(fb_addr), 0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    int gp[4];
    gp = '{90, 30, 5, 60};
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // 1: single write, one-cycle latency
    fb_grant = 1'b1;
    request(16'd5, 16'h0741);
    check("t1_we", 32'(fb_we), 1);
    check("t1_addr", 32'(fb_addr), 5);
    check("t1_data", 32'(fb_data), 32'h0741);
    @(posedge clock); #1;
    check("t1_busy_idle", 32'(busy), 0);

    // 2: grant withheld, fill, overflow, then ordered drain
    do_reset();
    fb_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      request(16'(i), 16'(16'h0100 + i));
      if (i == 7) check("t2_full_after_8", 32'(full), 1);
    end
    check("t2_drop", 32'(drop_count), 2);
    log_addr.delete(); log_data.delete();
    @(posedge clock); #1 fb_grant = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    check("t2_nwrites", log_addr.size(), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++)
      check("t2_order", 32'(log_addr[i]), i);
    check("t2_busy_idle", 32'(busy), 0);

    // 3: held strobe is one request; pos 1200 rejected
    do_reset();
    fb_grant = 1'b1;
    log_addr.delete(); log_data.delete();
    @(posedge clock); #1;
    videoflag = 1'b1; vga_pos = 16'd3; vga_char = 16'h1133;
    repeat (20) @(posedge clock);
    #1 videoflag = 1'b0;
    repeat (3) @(posedge clock);
    request(16'd1200, 16'h2222);
    repeat (3) @(posedge clock);
    #1;
    check("t3_nwrites", log_addr.size(), 1);
    if (log_addr.size() > 0) check("t3_addr", 32'(log_addr[0]), 3);
    check("t3_drop", 32'(drop_count), 1);

    // 4: saturation, then asynchronous reset mid-cycle
    do_reset();
    fb_grant = 1'b0;
    for (int i = 0; i < 8; i++) request(16'(i + 20), 16'h0777);
    check("t4_full", 32'(full), 1);
    for (int i = 0; i < 300; i++) request(16'd10, 16'h0555);
    check("t4_drop_sat", 32'(drop_count), 255);
    @(negedge clock); #1;
    fb_grant = 1'b1;
    #1;
    check("t4_we_before_rst", 32'(fb_we), 1);
    midcycle_reset("t4_async");

`ifdef VGA_CLEAR_SCREEN_EN
    // 5: clear command fills the screen, then the queued write follows
    fb_grant = 1'b1;
    log_addr.delete(); log_data.delete();
    request(16'd5000, 16'hFFFF);
    check("t5_busy", 32'(busy), 1);
    request(16'd2, 16'h0042);
    for (int c = 0; c < 1500 && log_addr.size() < 1201; c++) @(posedge clock);
    #1;
    check("t5_nwrites", log_addr.size(), 1201);
    begin
      int n_bad = 0;
      for (int i = 0; i < 1200 && i < log_addr.size(); i++)
        if (log_addr[i] != 16'(i) || log_data[i] != 16'h0000) n_bad++;
      check("t5_fill_pattern", n_bad, 0);
    end
    if (log_addr.size() > 1200) begin
      check("t5_last_addr", 32'(log_addr[1200]), 2);
      check("t5_last_data", 32'(log_data[1200]), 32'h0042);
    end
    // reset aborts a clear at index 600
    request(16'd0, 16'hFFFF);
    begin
      bit found = 1'b0;
      for (int c = 0; c < 1500 && !found; c++) begin
        @(negedge clock); #1;
        if (fb_we && fb_addr == 11'd600) found = 1'b1;
      end
      check("t5_reached_600", 32'(found), 1);
    end
    midcycle_reset("t5_abort");
`else
    // 6: 16'hFFFF is an ordinary character without the clear feature
    fb_grant = 1'b1;
    log_addr.delete(); log_data.delete();
    request(16'd7, 16'hFFFF);
    repeat (3) @(posedge clock);
    #1;
    check("t6_nwrites", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      check("t6_addr", 32'(log_addr[0]), 7);
      check("t6_data", 32'(log_data[0]), 32'hFFFF);
    end
`endif

    // randomized phases with differing grant density
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 800; c++) begin
        @(posedge clock); #1;
        fb_grant  = ($urandom_range(0, 99) < gp[ph]);
        videoflag = ($urandom_range(0, 2) == 0);
        vga_pos   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1200, 65535))
                                                : 16'($urandom_range(0, 1199));
        vga_char  = ($urandom_range(0, 255) == 0) ? 16'hFFFF : 16'($urandom);
        reset     = ($urandom_range(0, 999) == 0);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0; videoflag = 1'b0;
    repeat (4) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
